edge_delay_trigger: RTL and testbench
=====================================

EDGE_DELAY_TRIGGER -- requirements
Module: edge_delay_trigger

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent trigger channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of each channel's delay count.
REQ-003 The block SHALL have parameter RETRIG, default 0, meaning the retrigger mode: 0 ignores edges while waiting, 1 restarts the wait.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, NUM_CH bits: per-channel start request; its rising edge starts that channel.
REQ-007 The block SHALL have port delay, input, NUM_CH*CNT_W bits: the per-channel wait length D in clk cycles, with channel i in bits [i*CNT_W +: CNT_W].
REQ-008 The block SHALL have port trigger, output, NUM_CH bits: per-channel level; 0 while waiting, 1 once the wait completes.
REQ-009 The block SHALL have port trig_pulse, output, NUM_CH bits: one-cycle strobe, high in the cycle trigger rises.
REQ-010 The block SHALL have port busy, output, NUM_CH bits: high while the channel is in WAIT.

Function
REQ-011 Each channel SHALL register enable as enable_q and SHALL detect a rising edge when enable=1 and enable_q=0 at a clk edge.
REQ-012 Each channel SHALL implement the states IDLE and WAIT.
REQ-013 On an edge detected at clk edge k in IDLE, the channel SHALL set trigger=0, busy=1, cnt=Deff-1 and go to WAIT.
REQ-014 Deff SHALL equal D, except that D=0 SHALL be treated as Deff=1.
REQ-015 D SHALL be sampled only at the starting edge; later changes to delay SHALL NOT affect a wait in progress.
REQ-016 In WAIT, while cnt is nonzero, cnt SHALL decrement by 1 at each clk edge.
REQ-017 In WAIT with cnt=0, the next clk edge SHALL set trigger=1, trig_pulse=1 and busy=0, and return the channel to IDLE.
REQ-018 The latency SHALL be exact: trigger goes high after clk edge k+Deff.
REQ-019 trigger SHALL hold its value in IDLE; it stays 1 after completion until the next accepted edge.
REQ-020 trig_pulse SHALL be high for exactly one cycle per completion and SHALL be 0 otherwise.
REQ-021 With RETRIG=0, an edge arriving during WAIT, including in the completion cycle, SHALL be ignored.
REQ-022 With RETRIG=1, an edge arriving during WAIT SHALL reload cnt=Deff-1 from the current delay, keep trigger=0, and produce no pulse.
REQ-023 With RETRIG=1, an edge coinciding with the completion cycle SHALL restart the wait (restart wins): trigger stays 0 and trig_pulse stays 0.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be handled per REQ-013.
REQ-025 The counter SHALL never wrap: the maximum D of 2^CNT_W-1 gives exactly 2^CNT_W-1 cycles.

Reset
REQ-026 While rst=1 at a clk edge, every channel SHALL go to IDLE with trigger=0, trig_pulse=0, busy=0, cnt=0 and enable_q=0.
REQ-027 Reset mid-wait SHALL abort the wait with no pulse.
REQ-028 If enable is high at the first edge after reset is released, that SHALL be treated as a rising edge.
REQ-029 Reset SHALL take priority over any edge in the same cycle.

Structure
REQ-030 The shared package edge_delay_pkg SHALL hold the state enum {IDLE, WAIT} and the default parameter constants.
REQ-031 The per-channel logic SHALL be the sub-module edge_delay_channel, instantiated NUM_CH times by a generate loop.
REQ-032 The top level SHALL contain only slicing and instantiation, with no additional logic.

Verification
REQ-033 The bench SHALL check basic delay: ch0 D=5, enable pulsed high for 1 cycle at edge 10 -> trigger=0 from edge 10, trigger=1 and trig_pulse=1 at edge 15, busy high for edges 10-14.
REQ-034 The bench SHALL check the D=0 and maximum-D boundaries: D=0 -> trigger rises 1 edge after the start; CNT_W=4 with D=15 -> trigger rises 15 edges after the start.
REQ-035 The bench SHALL check RETRIG=0 versus RETRIG=1 with D=5, start at edge 10 and a second edge at edge 13 -> RETRIG=0 gives trigger at edge 15; RETRIG=1 gives trigger at edge 18 with a single pulse.
REQ-036 The bench SHALL check an edge coinciding with completion (D=3, start at edge 10, second edge at edge 13) -> RETRIG=0 gives pulse at edge 13 and the edge is ignored; RETRIG=1 gives no pulse at edge 13 and trigger at edge 16.
REQ-037 The bench SHALL check reset mid-wait: rst asserted at edge 12 during a D=5 wait -> all outputs 0 at edge 12, and no pulse at edge 15.
REQ-038 The bench SHALL check independent channels: ch0 D=2 and ch1 D=7 started at the same edge -> pulses at +2 and +7 respectively, and changing delay mid-wait has no effect.

Source files
------------

// File: rtl/edge_delay_pkg.sv
// rtl/edge_delay_pkg.sv - shared state type and default parameters for the edge delay trigger
package edge_delay_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_RETRIG = 0;

endpackage

// File: rtl/edge_delay_channel.sv
// rtl/edge_delay_channel.sv - one channel: rising edge on enable starts a D-cycle wait, then raises trigger
module edge_delay_channel
    import edge_delay_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int RETRIG = DEF_RETRIG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] delay,
    output logic             trigger,
    output logic             trig_pulse,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] load_val;
    logic             trig_q;
    logic             trig_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             enable_q;
    logic             rise;

    assign rise = enable & ~enable_q;

    // The start edge itself is the first cycle of the wait, so load D-1; D=0 behaves as D=1.
    assign load_val = (delay == '0) ? '0 : delay - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            trig_q   <= 1'b0;
            pulse_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            trig_q   <= trig_d;
            pulse_q  <= pulse_d;
            enable_q <= enable;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = WAIT;
                    cnt_d   = load_val;
                    trig_d  = 1'b0;
                end
            end
            WAIT: begin
                // A restart edge beats completion when both land on the same cycle.
                if ((RETRIG != 0) && rise) begin
                    cnt_d = load_val;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    trig_d  = 1'b1;
                    pulse_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign trigger    = trig_q;
    assign trig_pulse = pulse_q;
    assign busy       = (state_q == WAIT);

endmodule

// File: rtl/edge_delay_trigger.sv
// rtl/edge_delay_trigger.sv - NUM_CH independent edge-started delay triggers
module edge_delay_trigger
    import edge_delay_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int RETRIG = DEF_RETRIG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] delay,
    output logic [NUM_CH-1:0]       trigger,
    output logic [NUM_CH-1:0]       trig_pulse,
    output logic [NUM_CH-1:0]       busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_delay_channel #(
            .CNT_W  (CNT_W),
            .RETRIG (RETRIG)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable[i]),
            .delay      (delay[i*CNT_W +: CNT_W]),
            .trigger    (trigger[i]),
            .trig_pulse (trig_pulse[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_edge_delay_trigger.sv
// tb/tb_edge_delay_trigger.sv - directed and randomized checks of edge_delay_trigger against a deadline model
module tb_edge_delay_trigger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en  = '0;
    logic [15:0] dly = '0;
    logic        en2 = 1'b0;
    logic [3:0]  dly2 = '0;

    logic [1:0] trig0, pul0, busy0;
    logic [1:0] trig1, pul1, busy1;
    logic       trig2, pul2, busy2;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    edge_delay_trigger #(.NUM_CH(2), .CNT_W(8), .RETRIG(0)) dut0 (
        .clk(clk), .rst(rst), .enable(en), .delay(dly),
        .trigger(trig0), .trig_pulse(pul0), .busy(busy0));

    edge_delay_trigger #(.NUM_CH(2), .CNT_W(8), .RETRIG(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en), .delay(dly),
        .trigger(trig1), .trig_pulse(pul1), .busy(busy1));

    edge_delay_trigger #(.NUM_CH(1), .CNT_W(4), .RETRIG(0)) dut2 (
        .clk(clk), .rst(rst), .enable(en2), .delay(dly2),
        .trigger(trig2), .trig_pulse(pul2), .busy(busy2));

    // Reference: each active wait is an absolute deadline cycle (start edge + Deff).
    int   dead   [3][2];
    logic mtrig  [3][2];
    logic mpulse [3][2];
    logic mq     [3][2];

    always @(posedge clk) begin
        int   dv;
        int   deff;
        logic e;
        logic rise;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 2; c++) begin
                if (!(d == 2 && c == 1)) begin
                    e    = (d == 2) ? en2 : en[c];
                    dv   = (d == 2) ? int'(dly2) : int'(dly[c*8 +: 8]);
                    deff = (dv == 0) ? 1 : dv;
                    rise = e && !mq[d][c];
                    mpulse[d][c] = 1'b0;
                    if (rst) begin
                        dead[d][c]  = -1;
                        mtrig[d][c] = 1'b0;
                        mq[d][c]    = 1'b0;
                    end else begin
                        if (dead[d][c] >= 0 && rise && d == 1) begin
                            dead[d][c] = cyc + deff;
                        end else if (dead[d][c] >= 0 && cyc == dead[d][c]) begin
                            mtrig[d][c]  = 1'b1;
                            mpulse[d][c] = 1'b1;
                            dead[d][c]   = -1;
                        end else if (dead[d][c] < 0 && rise) begin
                            dead[d][c]  = cyc + deff;
                            mtrig[d][c] = 1'b0;
                        end
                        mq[d][c] = e;
                    end
                end
            end
        end
    end

    function automatic logic [2:0] get_out(int d, int c);
        if (d == 0) return {trig0[c], pul0[c], busy0[c]};
        if (d == 1) return {trig1[c], pul1[c], busy1[c]};
        return {trig2, pul2, busy2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '0;
        en2 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        dly = {8'd4, 8'd4};
        en  = 2'b11;
        en2 = 1'b1;
        rst = 1'b1;
        tick();
        nvec++;
        if ({trig0, pul0, busy0, trig1, pul1, busy1, trig2, pul2, busy2} !== 15'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {trig0, pul0, busy0, trig1, pul1, busy1, trig2, pul2, busy2});
        end
        rst = 1'b0;
        tick();
        nvec++;
        if (busy0 !== 2'b11 || trig0 !== 2'b00) begin
            nerr++;
            $display("FAIL enable_high_after_reset: busy=%b trig=%b, want busy=11 trig=00", busy0, trig0);
        end
        do_reset();
    endtask

    task automatic test_basic();
        dly = {8'd9, 8'd5};
        tick();
        en = 2'b01;
        tick();
        en = 2'b00;
        for (int k = 10; k <= 14; k++) begin
            nvec++;
            if (trig0[0] !== 1'b0 || busy0[0] !== 1'b1 || pul0[0] !== 1'b0) begin
                nerr++;
                $display("FAIL basic_wait edge %0d: trig=%b busy=%b pulse=%b, want 0 1 0",
                         k, trig0[0], busy0[0], pul0[0]);
            end
            tick();
        end
        nvec++;
        if (trig0[0] !== 1'b1 || pul0[0] !== 1'b1 || busy0[0] !== 1'b0 ||
            trig1[0] !== 1'b1 || pul1[0] !== 1'b1) begin
            nerr++;
            $display("FAIL basic_fire edge 15: r0 trig=%b pulse=%b busy=%b r1 trig=%b pulse=%b, want 1 1 0 1 1",
                     trig0[0], pul0[0], busy0[0], trig1[0], pul1[0]);
        end
        tick();
        nvec++;
        if (trig0[0] !== 1'b1 || pul0[0] !== 1'b0) begin
            nerr++;
            $display("FAIL basic_hold edge 16: trig=%b pulse=%b, want 1 0", trig0[0], pul0[0]);
        end
    endtask

    task automatic test_boundaries();
        int seen;
        do_reset();
        dly = {8'd3, 8'd0};
        en  = 2'b01;
        tick();
        en  = 2'b00;
        nvec++;
        if (busy0[0] !== 1'b1 || trig0[0] !== 1'b0) begin
            nerr++;
            $display("FAIL d0_start: busy=%b trig=%b, want 1 0", busy0[0], trig0[0]);
        end
        tick();
        nvec++;
        if (trig0[0] !== 1'b1 || pul0[0] !== 1'b1) begin
            nerr++;
            $display("FAIL d0_fire: trig=%b pulse=%b, want 1 1", trig0[0], pul0[0]);
        end
        dly2 = 4'd15;
        en2  = 1'b1;
        tick();
        en2  = 1'b0;
        seen = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (pul2 === 1'b1 && seen < 0) seen = k;
        end
        nvec++;
        if (seen != 15) begin
            nerr++;
            $display("FAIL dmax_latency: pulse at +%0d, want +15", seen);
        end
    endtask

    task automatic test_retrig();
        int first0, first1, cnt0, cnt1;
        do_reset();
        dly = {8'd1, 8'd5};
        en  = 2'b01;
        tick();
        en  = 2'b00;
        tick();
        tick();
        en  = 2'b01;
        tick();
        en  = 2'b00;
        first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0;
        for (int k = 14; k <= 25; k++) begin
            tick();
            if (pul0[0] === 1'b1) begin cnt0++; if (first0 < 0) first0 = k; end
            if (pul1[0] === 1'b1) begin cnt1++; if (first1 < 0) first1 = k; end
        end
        nvec++;
        if (first0 != 15 || cnt0 != 1) begin
            nerr++;
            $display("FAIL retrig0: pulse at %0d count %0d, want 15 count 1", first0, cnt0);
        end
        nvec++;
        if (first1 != 18 || cnt1 != 1) begin
            nerr++;
            $display("FAIL retrig1: pulse at %0d count %0d, want 18 count 1", first1, cnt1);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        dly = {8'd1, 8'd3};
        en  = 2'b01;
        tick();
        en  = 2'b00;
        tick();
        tick();
        en  = 2'b01;
        tick();
        en  = 2'b00;
        nvec++;
        if (pul0[0] !== 1'b1 || trig0[0] !== 1'b1) begin
            nerr++;
            $display("FAIL coincide_r0 edge 13: pulse=%b trig=%b, want 1 1", pul0[0], trig0[0]);
        end
        nvec++;
        if (pul1[0] !== 1'b0 || trig1[0] !== 1'b0 || busy1[0] !== 1'b1) begin
            nerr++;
            $display("FAIL coincide_r1 edge 13: pulse=%b trig=%b busy=%b, want 0 0 1", pul1[0], trig1[0], busy1[0]);
        end
        tick();
        nvec++;
        if (busy0[0] !== 1'b0 || trig0[0] !== 1'b1) begin
            nerr++;
            $display("FAIL coincide_r0_ignored edge 14: busy=%b trig=%b, want 0 1", busy0[0], trig0[0]);
        end
        tick();
        tick();
        nvec++;
        if (pul1[0] !== 1'b1 || trig1[0] !== 1'b1) begin
            nerr++;
            $display("FAIL coincide_r1 edge 16: pulse=%b trig=%b, want 1 1", pul1[0], trig1[0]);
        end
    endtask

    task automatic test_reset_midwait();
        int pulses;
        do_reset();
        dly = {8'd1, 8'd5};
        en  = 2'b01;
        tick();
        en  = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if (trig0[0] !== 1'b0 || pul0[0] !== 1'b0 || busy0[0] !== 1'b0) begin
            nerr++;
            $display("FAIL midwait_reset edge 12: trig=%b pulse=%b busy=%b, want 0 0 0", trig0[0], pul0[0], busy0[0]);
        end
        pulses = 0;
        for (int k = 13; k <= 16; k++) begin
            tick();
            if (pul0[0] === 1'b1 || trig0[0] === 1'b1) pulses++;
        end
        nvec++;
        if (pulses != 0) begin
            nerr++;
            $display("FAIL midwait_no_pulse: %0d cycles with pulse/trigger, want 0", pulses);
        end
    endtask

    task automatic test_independent();
        logic [1:0] exp_p;
        do_reset();
        dly = {8'd7, 8'd2};
        en  = 2'b11;
        tick();
        en  = 2'b00;
        dly = {8'd1, 8'd1};
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_p = (k == 2) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00;
            nvec++;
            if (pul0 !== exp_p || pul1 !== exp_p) begin
                nerr++;
                $display("FAIL independent +%0d: r0 pulse=%b r1 pulse=%b, want %b", k, pul0, pul1, exp_p);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] got;
        logic [2:0] exp;
        for (int n = 0; n < 800; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            en   = 2'($urandom_range(0, 3));
            en2  = 1'($urandom_range(0, 1));
            dly  = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
            dly2 = 4'($urandom_range(0, 15));
            tick();
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < 2; c++) begin
                    if (!(d == 2 && c == 1)) begin
                        got = get_out(d, c);
                        exp = {mtrig[d][c], mpulse[d][c], dead[d][c] >= 0};
                        nvec++;
                        if (got !== exp) begin
                            nerr++;
                            $display("FAIL random cyc %0d dut%0d ch%0d: trig/pulse/busy=%b, want %b",
                                     cyc, d, c, got, exp);
                        end
                    end
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 2; c++) begin
                dead[d][c]   = -1;
                mtrig[d][c]  = 1'b0;
                mpulse[d][c] = 1'b0;
                mq[d][c]     = 1'b0;
            end
        end
        tick();
        test_reset();
        test_basic();
        test_boundaries();
        test_retrig();
        test_coincide();
        test_reset_midwait();
        test_independent();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
